mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Responder side of the stage-counter start/blocked handshake. Consumes the one-cycle start_fetch and
//  start_memory pulses, runs the instruction fetch or load/store on a req/ack memory bus, and holds
//  blocked high so the stage counter stalls until the access is done. Sits between the stage counter,
//  the PC / ALU address path, and the memory bus; delivers the fetched instruction and load result.
// PARAMETERS
//  XLEN       32  data/address width (fixed 32 for RV32I; 4 byte lanes)
//  TIMEOUT    16  max cycles bus_req may stay unacked before access_fault (must be >= 1)
// PORTS
//  clk           in   1     clock, all state on posedge
//  rst           in   1     synchronous, active-high reset
//  start_fetch   in   1     1-cycle pulse: fetch instruction at pc
//  start_memory  in   1     1-cycle pulse: perform memory stage of current instruction
//  pc            in   XLEN  fetch address, sampled in start_fetch cycle
//  mem_addr      in   XLEN  load/store byte address, sampled in start_memory cycle
//  mem_wdata     in   XLEN  store data (rs2), sampled in start_memory cycle
//  mem_funct3    in   3     access size/sign (RV32I funct3), sampled in start_memory cycle
//  mem_read      in   1     instruction is a load
//  mem_write     in   1     instruction is a store (mem_read & mem_write both high = fault)
//  blocked       out  1     stall request to stage counter
//  instr         out  XLEN  last successfully fetched instruction
//  instr_valid   out  1     instr holds result of most recent fetch
//  load_data     out  XLEN  aligned, extended result of most recent load
//  access_fault  out  1     most recent access failed (misaligned, bad funct3, timeout)
//  bus_req       out  1     bus request, registered
//  bus_we        out  1     write enable, valid with bus_req
//  bus_addr      out  XLEN  word-aligned address {addr[31:2],2'b00}
//  bus_wdata     out  XLEN  store data replicated into lanes
//  bus_wstrb     out  4     byte strobes for stores, 0 for reads
//  bus_ack       in   1     completes the current request (sampled only while bus_req=1)
//  bus_rdata     in   XLEN  read data, valid with bus_ack
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 (blocked, instr, instr_valid, load_data, access_fault, bus_*).
//  - States IDLE, FETCH, LOAD, STORE. blocked = start_accepted | (state != IDLE) (combinational, so the
//    counter stalls in the pulse cycle itself). start_accepted = start_fetch | (start_memory & (mem_read|mem_write)).
//  - IDLE + start_fetch: pc[1:0]!=0 -> access_fault<=1, stay IDLE; else FETCH, bus_req<=1, bus_we<=0,
//    instr_valid<=0, access_fault<=0. start_fetch wins if both pulses arrive together (start_memory dropped).
//  - IDLE + start_memory, neither read nor write: no-op, blocked stays 0.
//  - Load/store checks: funct3 load {000 LB,001 LH,010 LW,100 LBU,101 LHU}, store {000,001,010};
//    other codes, both read&write, halfword addr[0]=1, word addr[1:0]!=0 -> access_fault<=1, no bus cycle.
//  - Store: wstrb SB 0001<<a[1:0], SH 0011<<a[1:0], SW 1111; wdata SB {4{b}}, SH {2{h}}, SW w.
//  - Bus: bus_req stays high, all bus_* stable, until bus_ack. On ack: bus_req<=0, state<=IDLE;
//    FETCH: instr<=bus_rdata, instr_valid<=1; LOAD: load_data<=lane-shifted, sign/zero-extended rdata.
//  - Latency: zero-wait memory (ack in first req cycle) -> blocked high exactly 2 cycles (pulse cycle + 1);
//    each wait cycle adds 1. Fault-on-check -> blocked high 1 cycle (pulse cycle only).
//  - Timeout: counter cleared on entering FETCH/LOAD/STORE, counts req cycles; after TIMEOUT cycles
//    without ack -> bus_req<=0, access_fault<=1, IDLE. Ack arriving in the timeout cycle counts as success.
//  - Start pulses while state != IDLE are ignored. bus_ack while bus_req=0 is ignored.
//  - instr, load_data hold until next successful access of that kind; access_fault holds until next accepted start.
//  - rst mid-access: IDLE next cycle, bus_req drops, pending ack discarded, outputs cleared.
// STRUCTURE
//  - arch_defines.v: RV32I funct3 load/store codes, MAU state encodings (MAU_IDLE..MAU_STORE).
//  - Sub-module load_store_align (combinational): store lane/wstrb generation, load extraction/extension,
//    misalignment check; FSM, timeout counter and bus registers stay in mem_access_unit.
// TESTING
//  1. Fetch pc=0x100, ack 1st req cycle, rdata=0x00500093 -> bus_addr=0x100, blocked 2 cycles, instr=0x00500093, instr_valid=1.
//  2. LB addr=0x203, rdata=0x80AA55CC -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LH 0x202 -> 0xFFFF80AA.
//  3. SH addr=0x302 wdata=0x1234BEEF -> bus_we=1, bus_addr=0x300, wstrb=1100, wdata=0xBEEFBEEF.
//  4. LW addr=0x401 -> access_fault=1, blocked 1 cycle, bus_req never rises; funct3=011 load -> same.
//  5. Fetch with ack held low, TIMEOUT=16 -> bus_req 16 cycles, then access_fault=1, blocked low next cycle.
//  6. rst asserted 2 cycles into 3-wait-state load, ack then arrives -> all outputs 0, load_data unchanged at 0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared state encoding and access-size codes for the memory access unit
package mem_access_unit_pkg;
   typedef enum logic [1:0] {MAU_IDLE, MAU_FETCH, MAU_LOAD, MAU_STORE} mau_state_e;
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
endpackage

// File: rtl/mem_access_unit_load_store_align.sv
// mem_access_unit_load_store_align: access legality, store lane steering and load extraction
module mem_access_unit_load_store_align
   import mem_access_unit_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic        read_i,
   input  logic        write_i,
   input  logic [31:0] wdata_i,
   input  logic [2:0]  ld_funct3_i,
   input  logic [1:0]  ld_off_i,
   input  logic [31:0] rdata_i,
   output logic        fault_o,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ld_data_o
);
   logic        bad_code;
   logic        misal;
   logic        sx;
   logic [15:0] sh;
   // reject illegal codes and misaligned addresses, steer store lanes, extract and extend load data
   always_comb begin
      bad_code  = (funct3_i[1:0] == 2'b11) | (funct3_i[2] & (write_i | funct3_i[1]));
      misal     = ((funct3_i[1:0] == SZ_H) & off_i[0]) | ((funct3_i[1:0] == SZ_W) & (off_i != 2'b00));
      fault_o   = (read_i & write_i) | bad_code | misal;
      wstrb_o   = funct3_i[1:0] == SZ_B ? 4'b0001 << off_i :
                  funct3_i[1:0] == SZ_H ? 4'b0011 << off_i : 4'b1111;
      wdata_o   = funct3_i[1:0] == SZ_B ? {4{wdata_i[7:0]}} :
                  funct3_i[1:0] == SZ_H ? {2{wdata_i[15:0]}} : wdata_i;
      sh        = 16'(rdata_i >> {ld_off_i, 3'b000});
      sx        = ~ld_funct3_i[2];
      ld_data_o = ld_funct3_i[1:0] == SZ_B ? {{24{sx & sh[7]}}, sh[7:0]} :
                  ld_funct3_i[1:0] == SZ_H ? {{16{sx & sh[15]}}, sh} : rdata_i;
   end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: runs fetch/load/store on a req/ack bus and stalls the stage counter until done
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_fetch,
   input  logic            start_memory,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] mem_addr,
   input  logic [XLEN-1:0] mem_wdata,
   input  logic [2:0]      mem_funct3,
   input  logic            mem_read,
   input  logic            mem_write,
   output logic            blocked,
   output logic [XLEN-1:0] instr,
   output logic            instr_valid,
   output logic [XLEN-1:0] load_data,
   output logic            access_fault,
   output logic            bus_req,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [XLEN-1:0] bus_wdata,
   output logic [3:0]      bus_wstrb,
   input  logic            bus_ack,
   input  logic [XLEN-1:0] bus_rdata
);
   localparam int CW = $clog2(TIMEOUT) + 1;
   mau_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            req_q, req_d;
   logic            we_q, we_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [3:0]      wstrb_q, wstrb_d;
   logic [2:0]      f3_q, f3_d;
   logic [1:0]      off_q, off_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic            iv_q, iv_d;
   logic [XLEN-1:0] ld_q, ld_d;
   logic            fault_q, fault_d;
   logic            idle;
   logic            acc_mem;
   logic            ls_fault;
   logic [3:0]      ls_wstrb;
   logic [XLEN-1:0] ls_wdata;
   logic [XLEN-1:0] ls_ld;

   mem_access_unit_load_store_align u_align (
      .funct3_i    (mem_funct3),
      .off_i       (mem_addr[1:0]),
      .read_i      (mem_read),
      .write_i     (mem_write),
      .wdata_i     (mem_wdata),
      .ld_funct3_i (f3_q),
      .ld_off_i    (off_q),
      .rdata_i     (bus_rdata),
      .fault_o     (ls_fault),
      .wstrb_o     (ls_wstrb),
      .wdata_o     (ls_wdata),
      .ld_data_o   (ls_ld)
   );

   assign idle    = state_q == MAU_IDLE;
   assign acc_mem = start_memory & (mem_read | mem_write);
   assign blocked = (idle & (start_fetch | acc_mem)) | ~idle;

   // accept starts in IDLE, then hold the bus request until ack or timeout
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      f3_d    = f3_q;
      off_d   = off_q;
      instr_d = instr_q;
      iv_d    = iv_q;
      ld_d    = ld_q;
      fault_d = fault_q;
      if (idle & start_fetch) begin
         fault_d = pc[1:0] != 2'b00;
         if (pc[1:0] == 2'b00) begin
            state_d = MAU_FETCH;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = {pc[XLEN-1:2], 2'b00};
            wstrb_d = 4'b0000;
            iv_d    = 1'b0;
         end
      end else if (idle & acc_mem) begin
         fault_d = ls_fault;
         if (!ls_fault) begin
            state_d = mem_write ? MAU_STORE : MAU_LOAD;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = mem_write;
            addr_d  = {mem_addr[XLEN-1:2], 2'b00};
            wdata_d = ls_wdata;
            wstrb_d = mem_write ? ls_wstrb : 4'b0000;
            f3_d    = mem_funct3;
            off_d   = mem_addr[1:0];
         end
      end else if (!idle) begin
         if (bus_ack) begin
            req_d   = 1'b0;
            state_d = MAU_IDLE;
            instr_d = state_q == MAU_FETCH ? bus_rdata : instr_q;
            iv_d    = state_q == MAU_FETCH ? 1'b1 : iv_q;
            ld_d    = state_q == MAU_LOAD ? ls_ld : ld_q;
         end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            req_d   = 1'b0;
            fault_d = 1'b1;
            state_d = MAU_IDLE;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MAU_IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         f3_q    <= '0;
         off_q   <= '0;
         instr_q <= '0;
         iv_q    <= 1'b0;
         ld_q    <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         instr_q <= instr_d;
         iv_q    <= iv_d;
         ld_q    <= ld_d;
         fault_q <= fault_d;
      end
   end

   assign instr        = instr_q;
   assign instr_valid  = iv_q;
   assign load_data    = ld_q;
   assign access_fault = fault_q;
   assign bus_req      = req_q;
   assign bus_we       = we_q;
   assign bus_addr     = addr_q;
   assign bus_wdata    = wdata_q;
   assign bus_wstrb    = wstrb_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of the memory access unit against a behavioural model
module tb_mem_access_unit;
   localparam int TO = 16;
   localparam int NC = TO + 4;
   logic        clk = 1'b0;
   logic        rst;
   logic        start_fetch, start_memory, mem_read, mem_write, bus_ack;
   logic [31:0] pc, mem_addr, mem_wdata, bus_rdata;
   logic [2:0]  mem_funct3;
   logic        blocked, instr_valid, access_fault, bus_req, bus_we;
   logic [31:0] instr, load_data, bus_addr, bus_wdata;
   logic [3:0]  bus_wstrb;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_instr, m_ld;
   logic        m_iv, m_fault;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_wstrb;
   logic        cap_we, cap_stable;
   int          n_blk, n_req;

   always #5 clk = ~clk;

   mem_access_unit #(.XLEN(32), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_fetch  (start_fetch),
      .start_memory (start_memory),
      .pc           (pc),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_funct3   (mem_funct3),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .blocked      (blocked),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .load_data    (load_data),
      .access_fault (access_fault),
      .bus_req      (bus_req),
      .bus_we       (bus_we),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_wstrb    (bus_wstrb),
      .bus_ack      (bus_ack),
      .bus_rdata    (bus_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // kind: 0 fetch, 1 load, 2 store, 3 memory pulse with no read/write, 4 read and write together
   task automatic run_op(input int kind, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd,
                         input logic [31:0] rd, input int waits, input bit poke);
      int         size, off, exp_blk, exp_req;
      bit         rd_op, wr_op, bad, go;
      logic [63:0] v;
      size  = 1 << f3[1:0];
      off   = int'(a[1:0]);
      rd_op = kind == 1 || kind == 4;
      wr_op = kind == 2 || kind == 4;
      go    = kind != 3;
      if (kind == 0) bad = a[1:0] != 2'b00;
      else if (kind == 3) bad = 1'b0;
      else bad = (rd_op && wr_op) || f3 == 3'd3 || f3 > 3'd5 || (wr_op && f3 > 3'd2) || (off % size) != 0;
      @(negedge clk);
      start_fetch  = kind == 0;
      start_memory = kind != 0;
      pc           = a;
      mem_addr     = a;
      mem_wdata    = wd;
      mem_funct3   = f3;
      mem_read     = rd_op;
      mem_write    = wr_op;
      bus_rdata    = rd;
      n_blk        = 0;
      n_req        = 0;
      cap_stable   = 1'b1;
      for (int c = 0; c < NC; c++) begin
         #1;
         if (blocked) n_blk++;
         bus_ack = 1'b0;
         if (bus_req) begin
            n_req++;
            if (n_req == 1) begin
               cap_addr  = bus_addr;
               cap_wdata = bus_wdata;
               cap_wstrb = bus_wstrb;
               cap_we    = bus_we;
            end else if ({bus_addr, bus_wdata, bus_wstrb, bus_we} !== {cap_addr, cap_wdata, cap_wstrb, cap_we}) begin
               cap_stable = 1'b0;
            end
            bus_ack = n_req == waits + 1;
         end
         @(negedge clk);
         start_fetch  = poke && go && !bad && c == 0;
         start_memory = 1'b0;
         pc           = 32'h0000_0040;
      end
      start_fetch = 1'b0;
      bus_ack     = 1'b0;
      if (!go) begin
         exp_blk = 0;
         exp_req = 0;
      end else if (bad) begin
         exp_blk = 1;
         exp_req = 0;
         m_fault = 1'b1;
      end else if (waits >= TO) begin
         exp_blk = TO + 1;
         exp_req = TO;
         m_fault = 1'b1;
         if (kind == 0) m_iv = 1'b0;
      end else begin
         exp_blk = waits + 2;
         exp_req = waits + 1;
         m_fault = 1'b0;
         if (kind == 0) begin
            m_instr = rd;
            m_iv    = 1'b1;
         end
         if (kind == 1) begin
            v = ({32'b0, rd} >> (8 * off)) & ((64'd1 << (8 * size)) - 64'd1);
            if (f3 < 3'd4 && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
            m_ld = v[31:0];
         end
      end
      chk("blocked_cycles", 32'(n_blk), 32'(exp_blk));
      chk("req_cycles", 32'(n_req), 32'(exp_req));
      chk("access_fault", 32'(access_fault), 32'(m_fault));
      chk("instr", instr, m_instr);
      chk("instr_valid", 32'(instr_valid), 32'(m_iv));
      chk("load_data", load_data, m_ld);
      if (exp_req > 0) begin
         chk("bus_addr", cap_addr, a & 32'hFFFF_FFFC);
         chk("bus_we", 32'(cap_we), 32'(wr_op));
         chk("bus_stable", 32'(cap_stable), 32'd1);
         if (wr_op) begin
            chk("bus_wstrb", 32'(cap_wstrb), ((32'd1 << size) - 32'd1) << off);
            for (int k = 0; k < size; k++) chk("bus_wdata_lane", 32'(cap_wdata[8 * (off + k) +: 8]), 32'(wd[8 * k +: 8]));
         end else begin
            chk("bus_wstrb", 32'(cap_wstrb), 32'd0);
         end
      end
   endtask

   initial begin
      int         kind, waits, r;
      logic [2:0] f3;
      logic [31:0] a;
      logic [2:0] lf [5];
      lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      rst = 1'b1;
      start_fetch = 1'b0;
      start_memory = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      bus_ack = 1'b0;
      pc = '0;
      mem_addr = '0;
      mem_wdata = '0;
      bus_rdata = '0;
      mem_funct3 = '0;
      m_instr = '0;
      m_ld = '0;
      m_iv = 1'b0;
      m_fault = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_blocked", 32'(blocked), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_load_data", load_data, 32'd0);
      chk("rst_fault", 32'(access_fault), 32'd0);
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_bus_we", 32'(bus_we), 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_bus_wdata", bus_wdata, 32'd0);
      chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
      rst = 1'b0;

      run_op(0, 32'h100, 3'd0, 32'd0, 32'h0050_0093, 0, 1'b0);
      chk("fetch_instr_const", instr, 32'h0050_0093);
      chk("fetch_blocked_const", 32'(n_blk), 32'd2);
      run_op(1, 32'h203, 3'd0, 32'd0, 32'h80AA_55CC, 1, 1'b0);
      chk("lb_const", load_data, 32'hFFFF_FF80);
      run_op(1, 32'h203, 3'd4, 32'd0, 32'h80AA_55CC, 0, 1'b0);
      chk("lbu_const", load_data, 32'h0000_0080);
      run_op(1, 32'h202, 3'd1, 32'd0, 32'h80AA_55CC, 2, 1'b0);
      chk("lh_const", load_data, 32'hFFFF_80AA);
      run_op(2, 32'h302, 3'd1, 32'h1234_BEEF, 32'd0, 1, 1'b0);
      chk("sh_wstrb_const", 32'(cap_wstrb), 32'hC);
      chk("sh_wdata_const", cap_wdata, 32'hBEEF_BEEF);
      run_op(1, 32'h401, 3'd2, 32'd0, 32'd0, 0, 1'b0);
      run_op(1, 32'h400, 3'd3, 32'd0, 32'd0, 0, 1'b0);
      run_op(0, 32'h500, 3'd0, 32'd0, 32'hDEAD_BEEF, TO, 1'b0);
      run_op(0, 32'h504, 3'd0, 32'd0, 32'hCAFE_F00D, TO - 1, 1'b0);
      run_op(3, 32'h600, 3'd2, 32'd0, 32'd0, 0, 1'b0);
      run_op(4, 32'h600, 3'd2, 32'd0, 32'd0, 0, 1'b0);
      run_op(0, 32'h702, 3'd0, 32'd0, 32'd0, 0, 1'b0);
      run_op(2, 32'h800, 3'd2, 32'h0BAD_F00D, 32'd0, 0, 1'b1);

      for (int i = 0; i < 150; i++) begin
         kind = $urandom_range(0, 4);
         if (kind == 4 && $urandom_range(0, 3) != 0) kind = 1;
         if ($urandom_range(0, 5) == 0) f3 = 3'($urandom_range(0, 7));
         else if (kind == 2) f3 = 3'($urandom_range(0, 2));
         else f3 = lf[$urandom_range(0, 4)];
         a = $urandom & 32'h0000_FFFC;
         if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(0, 3));
         else if (kind != 0 && f3[1:0] == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
         else if (kind != 0 && f3[1:0] == 2'b01) a[1] = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 9);
         waits = r < 7 ? r % 4 : r == 7 ? TO - 1 : r == 8 ? TO : $urandom_range(4, 8);
         run_op(kind, a, f3, $urandom, $urandom, waits, 1'($urandom_range(0, 1)));
      end

      @(negedge clk);
      start_memory = 1'b1;
      mem_read = 1'b1;
      mem_write = 1'b0;
      mem_addr = 32'h200;
      mem_funct3 = 3'd2;
      @(negedge clk);
      start_memory = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus_ack = 1'b1;
      bus_rdata = 32'h1357_9BDF;
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      chk("midrst_blocked", 32'(blocked), 32'd0);
      chk("midrst_bus_req", 32'(bus_req), 32'd0);
      chk("midrst_load_data", load_data, 32'd0);
      chk("midrst_instr", instr, 32'd0);
      chk("midrst_instr_valid", 32'(instr_valid), 32'd0);
      chk("midrst_fault", 32'(access_fault), 32'd0);
      chk("midrst_bus_addr", bus_addr, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
